// File: rtl/uex_mem_pkg.sv
// ---------------------------------------------------------------------------
// uex_mem_pkg
// Shared types and width helpers for the memory access arbiter.
//   arb_state_e : request-path FSM states (IDLE waits for a grant, BUSY holds
//                 the registered request on the memory port until accepted).
//   id_width    : bits needed to name one of n channels (minimum 1).
//   cnt_width   : bits needed to count 0..depth inclusive.
// ---------------------------------------------------------------------------
package uex_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uex_mem_access_arb_if.sv
// ---------------------------------------------------------------------------
// uex_mem_access_arb_if
// Memory-side bus of the arbiter: one request channel with valid/ready
// handshake and one in-order response channel without backpressure.
//   master : arbiter side (drives request, receives ready and responses)
//   slave  : memory side
// ---------------------------------------------------------------------------
interface uex_mem_access_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic                    m_req_valid;
    logic                    m_req_ready;
    logic [ADDR_WIDTH-1:0]   m_addr;
    logic                    m_we;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH/8-1:0] m_wstrb;
    logic                    m_rsp_valid;
    logic [DATA_WIDTH-1:0]   m_rsp_rdata;

    modport master (
        output m_req_valid, m_addr, m_we, m_wdata, m_wstrb,
        input  m_req_ready, m_rsp_valid, m_rsp_rdata
    );

    modport slave (
        input  m_req_valid, m_addr, m_we, m_wdata, m_wstrb,
        output m_req_ready, m_rsp_valid, m_rsp_rdata
    );

endinterface

// File: rtl/uex_id_fifo.sv
// ---------------------------------------------------------------------------
// uex_id_fifo
// Small FIFO of channel IDs for issued-but-unanswered memory requests.
// Ports: clock, reset (sync, active-high), push/push_data, pop/pop_data,
//        full, empty, count (registered occupancy).
// When empty, pop_data shows push_data so a response arriving in the same
// cycle as the push of its own ID is routed without storing the entry.
// ---------------------------------------------------------------------------
module uex_id_fifo
    import uex_mem_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             bypass;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two pointer widths (DEPTH=1) stay correct
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign bypass   = empty && push && pop;
    assign do_push  = push && !full && !bypass;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? push_data : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uex_mem_access_arb.sv
// ---------------------------------------------------------------------------
// uex_mem_access_arb
// Round-robin arbiter giving N_CHANNELS requesters access to one memory port
// with up to MAX_OUTSTANDING in-order responses in flight.
// Ports:
//   clock, reset          sole clock, synchronous active-high reset
//   req_valid/req_ready   per-channel request handshake (ready is a pulse)
//   req_addr/we/wdata/wstrb  flattened per-channel payloads (channel i at slice i)
//   rsp_valid/rsp_rdata   per-channel response pulse, shared read data
//   err                   sticky flag for a response with nothing outstanding
//   mem                   memory-side bus (master modport)
// ---------------------------------------------------------------------------
module uex_mem_access_arb
    import uex_mem_pkg::*;
#(
    parameter int N_CHANNELS      = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [N_CHANNELS-1:0]            req_valid,
    output logic [N_CHANNELS-1:0]            req_ready,
    input  logic [N_CHANNELS*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_CHANNELS-1:0]            req_we,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] req_wdata,
    input  logic [N_CHANNELS*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [N_CHANNELS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             err,
    uex_mem_access_arb_if.master             mem
);

    localparam int ID_W   = id_width(N_CHANNELS);
    localparam int CNT_W  = cnt_width(MAX_OUTSTANDING);
    localparam int STRB_W = DATA_WIDTH / 8;

    arb_state_e            state_q;
    arb_state_e            state_d;
    logic [ID_W-1:0]       rr_ptr_q;
    logic [ID_W-1:0]       grant_id;
    logic                  grant_found;
    logic                  grant_fire;
    logic [ID_W-1:0]       grant_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  push;
    logic                  pop;
    logic [ID_W-1:0]       head_id;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  slots_free;

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
        return (int'(g) == N_CHANNELS - 1) ? '0 : g + ID_W'(1);
    endfunction

    // Registered count only: a response in this cycle frees its slot next cycle
    assign slots_free = (fifo_count < CNT_W'(MAX_OUTSTANDING));

    // A response is legal if an ID is queued or is being pushed this cycle
    assign pop = mem.m_rsp_valid && (!fifo_empty || push);

    // First requesting channel at or after rr_ptr, wrapping around
    always_comb begin
        logic [ID_W-1:0] idx;
        grant_id    = rr_ptr_q;
        grant_found = 1'b0;
        idx         = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            idx = ID_W'((int'(rr_ptr_q) + i) % N_CHANNELS);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        grant_fire = 1'b0;
        push       = 1'b0;
        req_ready  = '0;
        case (state_q)
            IDLE: begin
                if (grant_found && slots_free && !reset) begin
                    grant_fire          = 1'b1;
                    req_ready[grant_id] = 1'b1;
                    state_d             = BUSY;
                end
            end
            BUSY: begin
                if (mem.m_req_ready) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            err       <= 1'b0;
        end else begin
            if (grant_fire) begin
                rr_ptr_q <= next_ptr(grant_id);
                grant_q  <= grant_id;
                addr_q   <= req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
                we_q     <= req_we[grant_id];
                wdata_q  <= req_wdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                wstrb_q  <= req_wstrb[int'(grant_id)*STRB_W +: STRB_W];
            end
            rsp_valid <= '0;
            if (pop) begin
                rsp_valid[head_id] <= 1'b1;
                rsp_rdata          <= mem.m_rsp_rdata;
            end
            if (mem.m_rsp_valid && !pop) err <= 1'b1;
        end
    end

    // The slot check at grant time guarantees room when the push arrives
    always_ff @(posedge clock) begin
        if (!reset) assert (!(push && fifo_full));
    end

    assign mem.m_req_valid = (state_q == BUSY);
    assign mem.m_addr      = addr_q;
    assign mem.m_we        = we_q;
    assign mem.m_wdata     = wdata_q;
    assign mem.m_wstrb     = wstrb_q;

    uex_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (grant_q),
        .pop       (pop),
        .pop_data  (head_id),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_uex_mem_access_arb.sv
// ---------------------------------------------------------------------------
// tb_uex_mem_access_arb
// Directed scenarios on a 4-deep instance, plus a slot-limit scenario and a
// randomized run against a queue-based reference model on a 2-deep instance.
// ---------------------------------------------------------------------------
module tb_uex_mem_access_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_we;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_wstrb;
    logic [N-1:0]    req_ready, req_ready2;
    logic [N-1:0]    rsp_valid, rsp_valid2;
    logic [DW-1:0]   rsp_rdata, rsp_rdata2;
    logic            err, err2;
    logic            m_req_ready;
    logic            m_rsp_valid;
    logic [DW-1:0]   m_rsp_rdata;

    int total = 0;
    int bad   = 0;

    uex_mem_access_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();
    uex_mem_access_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif2 ();

    assign mif.m_req_ready  = m_req_ready;
    assign mif.m_rsp_valid  = m_rsp_valid;
    assign mif.m_rsp_rdata  = m_rsp_rdata;
    assign mif2.m_req_ready = m_req_ready;
    assign mif2.m_rsp_valid = m_rsp_valid;
    assign mif2.m_rsp_rdata = m_rsp_rdata;

    uex_mem_access_arb #(
        .N_CHANNELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err),
        .mem(mif)
    );

    uex_mem_access_arb #(
        .N_CHANNELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2)
    ) dut2 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready2), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .err(err2),
        .mem(mif2)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        req_valid   = '0;
        req_addr    = '0;
        req_we      = '0;
        req_wdata   = '0;
        req_wstrb   = '0;
        m_req_ready = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        req_valid   = '1;
        m_rsp_valid = 1'b1;
        reset       = 1'b1;
        step();
        step();
        settle();
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
        total++; if (mif.m_req_valid !== 1'b0) begin bad++; $display("FAIL reset_m_req_valid got=%b want=0", mif.m_req_valid); end
        total++; if ({mif.m_addr, mif.m_we, mif.m_wdata, mif.m_wstrb} !== '0) begin bad++;
            $display("FAIL reset_m_bus got addr=%h we=%b wdata=%h wstrb=%h want all zero", mif.m_addr, mif.m_we, mif.m_wdata, mif.m_wstrb); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0000", rsp_valid); end
        total++; if (rsp_rdata !== '0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        idle_inputs();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        do_reset();
        req_valid                = 4'b0100;
        req_addr[2*AW +: AW]     = 32'h0000_0100;
        settle();
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b want=0100", req_ready); end
        step();
        req_valid = '0;
        settle();
        total++; if (mif.m_req_valid !== 1'b1 || mif.m_addr !== 32'h100 || mif.m_we !== 1'b0) begin bad++;
            $display("FAIL single_issue got valid=%b addr=%h we=%b want 1/00000100/0", mif.m_req_valid, mif.m_addr, mif.m_we); end
        m_req_ready = 1'b1;
        step();
        m_req_ready = 1'b0;
        step();
        step();
        m_rsp_valid = 1'b1;
        m_rsp_rdata = 32'h0000_DEAD;
        settle();
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL single_early got=%b want=0000", rsp_valid); end
        step();
        m_rsp_valid = 1'b0;
        settle();
        total++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 32'h0000_DEAD) begin bad++;
            $display("FAIL single_rsp got valid=%b rdata=%h want 0100/0000dead", rsp_valid, rsp_rdata); end
        step();
        settle();
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL single_pulse got=%b want=0000", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic         prev_issue;
        logic [N-1:0] want;
        do_reset();
        req_valid   = '1;
        m_req_ready = 1'b1;
        prev_issue  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            m_rsp_valid = prev_issue;
            m_rsp_rdata = $urandom;
            settle();
            want = '0;
            if (c % 2 == 0) want = N'(1) << ((c / 2) % N);
            total++; if (req_ready !== want) begin bad++; $display("FAIL rr_cycle%0d got=%b want=%b", c, req_ready, want); end
            prev_issue = mif.m_req_valid;
            step();
        end
        m_rsp_valid = 1'b0;
        settle();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rr_err got=%b want=0", err); end
    endtask

    task automatic test_outstanding();
        int           grants;
        bit           found;
        logic [N-1:0] third;
        do_reset();
        req_valid   = '1;
        m_req_ready = 1'b1;
        grants      = 0;
        for (int c = 0; c < 10; c++) begin
            settle();
            if (req_ready2 != '0) grants++;
            step();
        end
        total++; if (grants !== 2) begin bad++; $display("FAIL out_limit got=%0d want=2", grants); end
        m_rsp_valid = 1'b1;
        m_rsp_rdata = 32'h0BAD_F00D;
        settle();
        step();
        m_rsp_valid = 1'b0;
        settle();
        total++; if (rsp_valid2 !== 4'b0001 || rsp_rdata2 !== 32'h0BAD_F00D) begin bad++;
            $display("FAIL out_rsp got valid=%b rdata=%h want 0001/0badf00d", rsp_valid2, rsp_rdata2); end
        found = 1'b0;
        third = '0;
        for (int i = 0; i < 6 && !found; i++) begin
            if (i > 0) begin step(); settle(); end
            if (req_ready2 != '0) begin found = 1'b1; third = req_ready2; end
        end
        total++; if (third !== 4'b0100) begin bad++; $display("FAIL out_resume got=%b want=0100", third); end
    endtask

    task automatic test_stall();
        logic [AW+1+DW+SW-1:0] exp_bus;
        do_reset();
        req_valid              = 4'b1010;
        req_addr[1*AW +: AW]   = 32'hA5A0_0040;
        req_we[1]              = 1'b1;
        req_wdata[1*DW +: DW]  = 32'h1234_5678;
        req_wstrb[1*SW +: SW]  = 4'b0110;
        req_addr[3*AW +: AW]   = 32'h0000_0F00;
        settle();
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL stall_grant got=%b want=0010", req_ready); end
        step();
        req_valid = 4'b1000;
        exp_bus   = {32'hA5A0_0040, 1'b1, 32'h1234_5678, 4'b0110};
        for (int k = 0; k < 5; k++) begin
            settle();
            total++; if (mif.m_req_valid !== 1'b1 || {mif.m_addr, mif.m_we, mif.m_wdata, mif.m_wstrb} !== exp_bus) begin bad++;
                $display("FAIL stall_hold%0d got valid=%b bus=%h want 1/%h", k, mif.m_req_valid,
                         {mif.m_addr, mif.m_we, mif.m_wdata, mif.m_wstrb}, exp_bus); end
            total++; if (req_ready !== '0) begin bad++; $display("FAIL stall_no_grant%0d got=%b want=0000", k, req_ready); end
            step();
        end
        m_req_ready = 1'b1;
        step();
        m_req_ready = 1'b0;
        settle();
        total++; if (mif.m_req_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b want=0", mif.m_req_valid); end
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL stall_next_grant got=%b want=1000", req_ready); end
    endtask

    task automatic test_stray_response();
        do_reset();
        m_rsp_valid = 1'b1;
        m_rsp_rdata = 32'h0000_0BAD;
        step();
        m_rsp_valid = 1'b0;
        settle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL stray_err got=%b want=1", err); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL stray_rsp got=%b want=0000", rsp_valid); end
        repeat (3) step();
        settle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL stray_sticky got=%b want=1", err); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL stray_clear got=%b want=0", err); end
    endtask

    task automatic test_reset_busy();
        do_reset();
        req_valid   = 4'b0111;
        m_req_ready = 1'b1;
        repeat (4) step();
        m_req_ready = 1'b0;
        step();
        settle();
        total++; if (mif.m_req_valid !== 1'b1 || mif.m_addr !== 32'h0) begin bad++;
            $display("FAIL rb_busy got valid=%b addr=%h want 1/0", mif.m_req_valid, mif.m_addr); end
        req_valid = '0;
        reset     = 1'b1;
        step();
        settle();
        total++; if (mif.m_req_valid !== 1'b0 || req_ready !== '0 || rsp_valid !== '0 || err !== 1'b0) begin bad++;
            $display("FAIL rb_ctrl got m_req_valid=%b req_ready=%b rsp_valid=%b err=%b want all 0",
                     mif.m_req_valid, req_ready, rsp_valid, err); end
        total++; if ({mif.m_addr, mif.m_we, mif.m_wdata, mif.m_wstrb} !== '0 || rsp_rdata !== '0) begin bad++;
            $display("FAIL rb_data got addr=%h we=%b wdata=%h wstrb=%h rdata=%h want all 0",
                     mif.m_addr, mif.m_we, mif.m_wdata, mif.m_wstrb, rsp_rdata); end
        reset = 1'b0;
        step();
        m_rsp_valid = 1'b1;
        step();
        m_rsp_valid = 1'b0;
        settle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL rb_late_err got=%b want=1", err); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL rb_late_rsp got=%b want=0000", rsp_valid); end
    endtask

    // Reference: issued IDs kept in a queue, one pending bus transfer, and the
    // round-robin rule applied directly to the current request set.
    task automatic test_random();
        int            q[$];
        bit            busy;
        int            p_id;
        logic [AW-1:0] p_addr;
        logic          p_we;
        logic [DW-1:0] p_wdata;
        logic [SW-1:0] p_wstrb;
        int            rr;
        int            g;
        logic [N-1:0]  want;
        logic [N-1:0]  exp_rsp;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic [1:0]    ci;
        do_reset();
        busy = 1'b0; rr = 0; p_id = 0;
        p_addr = '0; p_we = 1'b0; p_wdata = '0; p_wstrb = '0;
        exp_rsp = '0; exp_rdata = '0; exp_err = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int ch = 0; ch < N; ch++) begin
                ci = 2'(ch);
                if (!req_valid[ci] && $urandom_range(1, 0) == 1) begin
                    req_valid[ci]          = 1'b1;
                    req_addr[ch*AW +: AW]  = $urandom;
                    req_we[ci]             = 1'($urandom_range(1, 0));
                    req_wdata[ch*DW +: DW] = $urandom;
                    req_wstrb[ch*SW +: SW] = 4'($urandom_range(15, 0));
                end
            end
            m_req_ready = ($urandom_range(2, 0) != 0);
            m_rsp_valid = (q.size() > 0) && ($urandom_range(2, 0) == 0);
            m_rsp_rdata = $urandom;
            settle();

            g = -1;
            if (!busy && q.size() < 2) begin
                for (int k = 0; k < N; k++) begin
                    ci = 2'((rr + k) % N);
                    if (g < 0 && req_valid[ci]) g = (rr + k) % N;
                end
            end
            want = '0;
            if (g >= 0) want = N'(1) << g;

            total++; if (req_ready2 !== want) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%b want=%b", cyc, req_ready2, want); end
            total++; if (mif2.m_req_valid !== busy) begin bad++; $display("FAIL rnd_m_valid cyc=%0d got=%b want=%b", cyc, mif2.m_req_valid, busy); end
            if (busy) begin
                total++; if ({mif2.m_addr, mif2.m_we, mif2.m_wdata, mif2.m_wstrb} !== {p_addr, p_we, p_wdata, p_wstrb}) begin bad++;
                    $display("FAIL rnd_m_bus cyc=%0d got=%h want=%h", cyc,
                             {mif2.m_addr, mif2.m_we, mif2.m_wdata, mif2.m_wstrb}, {p_addr, p_we, p_wdata, p_wstrb}); end
            end
            total++; if (rsp_valid2 !== exp_rsp) begin bad++; $display("FAIL rnd_rsp cyc=%0d got=%b want=%b", cyc, rsp_valid2, exp_rsp); end
            if (exp_rsp != '0) begin
                total++; if (rsp_rdata2 !== exp_rdata) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h want=%h", cyc, rsp_rdata2, exp_rdata); end
            end
            total++; if (err2 !== exp_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", cyc, err2, exp_err); end

            exp_rsp = '0;
            if (g >= 0) begin
                busy    = 1'b1;
                p_id    = g;
                p_addr  = req_addr[g*AW +: AW];
                p_we    = req_we[2'(g)];
                p_wdata = req_wdata[g*DW +: DW];
                p_wstrb = req_wstrb[g*SW +: SW];
                rr      = (g + 1) % N;
            end else if (busy && m_req_ready) begin
                q.push_back(p_id);
                busy = 1'b0;
            end
            if (m_rsp_valid) begin
                if (q.size() > 0) begin
                    exp_rsp   = N'(1) << q.pop_front();
                    exp_rdata = m_rsp_rdata;
                end else begin
                    exp_err = 1'b1;
                end
            end
            step();
            if (g >= 0) req_valid[2'(g)] = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_outstanding();
        test_stall();
        test_stray_response();
        test_reset_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
